// File: rtl/volume_apply.sv
// Applies a ramped volume gain to a signed 16-bit sample stream through a 2-stage pipeline.
// Latency is 2 cycles and one sample per cycle; both stages stall together when smpl_rdy_i is low.
module volume_apply (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  vol_lvl_i,
  input  logic        mute_i,
  input  logic [15:0] smpl_i,
  input  logic        smpl_val_i,
  output logic        smpl_rdy_o,
  output logic [15:0] smpl_o,
  output logic        smpl_val_o,
  input  logic        smpl_rdy_i,
  output logic        clip_o,
  output logic        ramping_o
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  localparam logic [6:0]         MAX_GAIN = 7'd80;
  localparam logic signed [22:0] SAT_MAX  = 23'sd32767;
  localparam logic signed [22:0] SAT_MIN  = -23'sd32768;

  state_t state, state_next;
  logic [6:0] target;
  logic [6:0] gain, gain_next;
  logic       en, accept;

  logic               s1_valid;
  logic signed [15:0] s1_smpl;
  logic [6:0]         s1_gain;
  logic signed [22:0] prod, shifted;
  logic [15:0]        sat;
  logic               sat_clip;

  assign en         = !smpl_val_o || smpl_rdy_i;
  assign smpl_rdy_o = en;
  assign accept     = smpl_val_i && en;
  assign ramping_o  = (state != IDLE);

  always_comb begin
    target = vol_lvl_i[6:0];
    if (mute_i)
      target = 7'd0;
    else if (vol_lvl_i > 8'd80)
      target = MAX_GAIN;
  end

  // Step direction comes from the registered state; the next state compares the
  // post-step gain so the ramp stops on the same accept that reaches the target.
  always_comb begin
    gain_next  = gain;
    state_next = IDLE;
    if (accept) begin
      case (state)
        UP:      gain_next = gain + 7'd1;
        DOWN:    gain_next = gain - 7'd1;
        default: gain_next = gain;
      endcase
    end
    if (gain_next < target)
      state_next = UP;
    else if (gain_next > target)
      state_next = DOWN;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      gain  <= 7'd0;
    end else begin
      state <= state_next;
      gain  <= gain_next;
    end
  end

  always_comb begin
    prod     = s1_smpl * $signed({1'b0, s1_gain});
    shifted  = prod >>> 6;
    sat      = shifted[15:0];
    sat_clip = 1'b0;
    if (shifted > SAT_MAX) begin
      sat      = 16'h7fff;
      sat_clip = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat      = 16'h8000;
      sat_clip = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid   <= 1'b0;
      s1_smpl    <= '0;
      s1_gain    <= '0;
      smpl_val_o <= 1'b0;
      smpl_o     <= '0;
      clip_o     <= 1'b0;
    end else if (en) begin
      s1_valid   <= smpl_val_i;
      s1_smpl    <= smpl_i;
      s1_gain    <= gain;
      smpl_val_o <= s1_valid;
      smpl_o     <= sat;
      clip_o     <= sat_clip;
    end
  end

endmodule
